// File: rtl/tm1638_pkg.sv
// Shared TM1638 protocol constants and responder FSM state type.
package tm1638_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int OP_MSB      = 7;
  localparam int OP_LSB      = 6;
  localparam int FIXED_BIT   = 2;
  localparam int READ_BIT    = 1;
  localparam int DISP_ON_BIT = 3;
  localparam int RAM_DEPTH   = 16;
  localparam int KEY_BITS    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_READ,
    ST_IGNORE
  } tm_state_e;

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; q_o is aligned with the pulses.
module tm1638_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device model: decodes master frames, holds display RAM, returns key-scan bits.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic        TM1638_STB,
  input  logic        TM1638_CLK,
  input  logic        TM1638_DIO_IN,
  output logic        TM1638_DIO_OUT,
  output logic        TM1638_DIO_OE,
  input  logic [31:0] KEYS,
  input  logic [3:0]  RAM_RADDR,
  output logic [7:0]  RAM_RDATA,
  output logic        RAM_WE,
  output logic [3:0]  RAM_WADDR,
  output logic [7:0]  RAM_WDATA,
  output logic        DISP_ON,
  output logic [2:0]  BRIGHTNESS,
  output logic        FRAME_ERR
);

  logic stb_rise, stb_fall, clk_rise, clk_fall, dio_s;
  logic unused_stb_lvl, unused_clk_lvl, unused_dio_rise, unused_dio_fall;

  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb (
    .clk_i(CLK_IN), .rst_i(RST_IN), .d_i(TM1638_STB),
    .q_o(unused_stb_lvl), .rise_o(stb_rise), .fall_o(stb_fall)
  );
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk (
    .clk_i(CLK_IN), .rst_i(RST_IN), .d_i(TM1638_CLK),
    .q_o(unused_clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dio (
    .clk_i(CLK_IN), .rst_i(RST_IN), .d_i(TM1638_DIO_IN),
    .q_o(dio_s), .rise_o(unused_dio_rise), .fall_o(unused_dio_fall)
  );

  tm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  addr_q, addr_d;
  logic        fixed_q, fixed_d, rmode_q, rmode_d;
  logic        disp_on_q, disp_on_d;
  logic [2:0]  bright_q, bright_d;
  logic        we_q, we_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ferr_q, ferr_d, oe_q, oe_d, dout_q, dout_d;
  logic [31:0] keys_q, keys_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]  byte_v;
  logic        byte_done;
  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    fixed_d   = fixed_q;
    rmode_d   = rmode_q;
    disp_on_d = disp_on_q;
    bright_d  = bright_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ferr_d    = 1'b0;
    oe_d      = oe_q;
    dout_d    = dout_q;
    keys_d    = keys_q;
    rd_cnt_d  = rd_cnt_q;
    byte_v    = {dio_s, sh_q[7:1]};
    byte_done = 1'b0;

    if (stb_rise) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      // A counter of 8 means the last byte closed cleanly; 0 means no bits at all.
      if (state_q != ST_IDLE && cnt_q != 4'd0 && cnt_q != 4'd8) ferr_d = 1'b1;
    end else if (stb_fall) begin
      cnt_d = 4'd0;
      if (state_q == ST_IDLE) state_d = ST_CMD;
    end else begin
      if (clk_rise && state_q != ST_IDLE) begin
        sh_d      = byte_v;
        cnt_d     = (cnt_q == 4'd8) ? 4'd1 : cnt_q + 4'd1;
        byte_done = (cnt_d == 4'd8);
        if (state_q == ST_READ && rd_cnt_q != 6'd32) rd_cnt_d = rd_cnt_q + 6'd1;
      end
      case (state_q)
        ST_CMD: begin
          if (byte_done) begin
            case (byte_v[OP_MSB:OP_LSB])
              CMD_DATA: begin
                fixed_d = byte_v[FIXED_BIT];
                rmode_d = byte_v[READ_BIT];
                if (byte_v[READ_BIT]) begin
                  state_d  = ST_READ;
                  keys_d   = KEYS;
                  rd_cnt_d = 6'd0;
                end else begin
                  state_d = ST_IGNORE;
                end
              end
              CMD_DISP: begin
                disp_on_d = byte_v[DISP_ON_BIT];
                bright_d  = byte_v[2:0];
                state_d   = ST_IGNORE;
              end
              CMD_ADDR: begin
                addr_d  = byte_v[3:0];
                state_d = ST_WDATA;
              end
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = byte_v;
            if (!fixed_q) addr_d = addr_q + 4'd1;
          end
        end
        ST_READ: begin
          if (clk_fall) begin
            if (rd_cnt_q == 6'd32) begin
              oe_d = 1'b0;
            end else begin
              oe_d   = 1'b1;
              dout_d = keys_q[rd_cnt_q[4:0]];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      sh_q      <= 8'h00;
      addr_q    <= 4'd0;
      fixed_q   <= 1'b0;
      rmode_q   <= 1'b0;
      disp_on_q <= 1'b0;
      bright_q  <= 3'd0;
      we_q      <= 1'b0;
      waddr_q   <= 4'd0;
      wdata_q   <= 8'h00;
      ferr_q    <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= 1'b0;
      keys_q    <= 32'h0;
      rd_cnt_q  <= 6'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      fixed_q   <= fixed_d;
      rmode_q   <= rmode_d;
      disp_on_q <= disp_on_d;
      bright_q  <= bright_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      ferr_q    <= ferr_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      keys_q    <= keys_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Read port samples the array before this cycle's write lands, so a collision returns old data.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      if (we_d) ram_q[waddr_d] <= wdata_d;
      rdata_q <= ram_q[RAM_RADDR];
    end
  end

  assign TM1638_DIO_OUT = dout_q;
  assign TM1638_DIO_OE  = oe_q;
  assign RAM_RDATA      = rdata_q;
  assign RAM_WE         = we_q;
  assign RAM_WADDR      = waddr_q;
  assign RAM_WDATA      = wdata_q;
  assign DISP_ON        = disp_on_q;
  assign BRIGHTNESS     = bright_q;
  assign FRAME_ERR      = ferr_q;

endmodule

// File: doc/tm1638_responder.md
# tm1638_responder

Bit-accurate TM1638 device model on the far end of the STB/CLK/DIO serial link that our controller drives. It decodes data, address and display-control commands, holds the 16-byte display RAM, and shifts a 32-bit key-scan image back during read frames. It is used as the loop-back target for controller benches and as an on-FPGA TM1638 emulator when no board is fitted. DIO is split into in/out/enable. The tristate sits at the top level.

## Interface
- SYNC_STAGES, 2: synchronizer depth on STB, CLK and DIO_IN (minimum 2).
- CLK_IN  in  1  system clock; all logic on rising edge.
- RST_IN  in  1  reset, synchronous, active-high.
- TM1638_STB  in  1  frame strobe, active-low.
- TM1638_CLK  in  1  serial clock from master; idles high.
- TM1638_DIO_IN  in  1  serial data from master, LSB first.
- TM1638_DIO_OUT  out  1  serial data to master during read frames.
- TM1638_DIO_OE  out  1  high while the responder drives DIO.
- KEYS  in  32  key-scan image; byte n = KEYS[8n+7:8n], byte 0 sent first.
- RAM_RADDR  in  4  user read address into display RAM.
- RAM_RDATA  out  8  registered RAM contents, one cycle after RAM_RADDR.
- RAM_WE  out  1  one-cycle pulse per display byte written.
- RAM_WADDR  out  4  address of that write.
- RAM_WDATA  out  8  data of that write.
- DISP_ON  out  1  display-control bit 3.
- BRIGHTNESS  out  3  display-control bits 2:0.
- FRAME_ERR  out  1  one-cycle pulse when STB rises mid-byte.

## Operation
- Inputs pass through SYNC_STAGES flops. Edge detect on the synced CLK gives a rise pulse and a fall pulse. Master CLK half-period must be at least 4 CLK_IN cycles.
- Bits are sampled on each synced CLK rise and shifted LSB first. A byte completes on the 8th rise. The bit counter clears on STB fall.
- FSM states: IDLE, CMD, WDATA, READ, IGNORE.
  - IDLE → CMD on STB fall.
  - Any state → IDLE on STB rise.
- CMD decodes the first byte of the frame using bits 7:6:
  - 01, data command. Latch fixed_addr = bit2 and read_mode = bit1. If read, go to READ. Otherwise go to IGNORE, and any further bytes in the frame are discarded.
  - 10, display control. Update DISP_ON and BRIGHTNESS, then go to IGNORE.
  - 11, address set. addr = bits 3:0, then go to WDATA.
  - 00, reserved. Go to IGNORE with no effect.
- WDATA: each completed byte writes RAM[addr] and pulses RAM_WE. addr then increments mod 16 (0xF → 0x0), unless fixed_addr is set. Writes occur regardless of read_mode.
- READ:
  - On entry, latch KEYS into a 32-bit shift register.
  - On the next CLK fall, assert DIO_OE and present bit 0.
  - Shift the next bit on each following fall.
  - Deassert OE on the fall after the 32nd read rise; extra clocks are ignored.
- fixed_addr and read_mode persist across frames. Reset values are 0 and 0.
- STB rise with the bit counter at neither 0 nor 8 discards the partial byte and pulses FRAME_ERR. A completed byte in the same frame stays committed.
- Reset values:
  - FSM, DISP_ON, BRIGHTNESS, RAM_WE, FRAME_ERR, DIO_OE and DIO_OUT: 0.
  - All 16 RAM bytes: 0x00. RAM_RDATA reads 0x00 one cycle after reset release.
  - Reset mid-frame aborts the frame without any write.
- A user read and a serial write to the same address in the same cycle: RAM_RDATA returns the old data.

## Timing
- Edge detect fires SYNC_STAGES+1 CLK_IN cycles after a pin edge.
- RAM_WE and the DISP_ON/BRIGHTNESS update occur 1 cycle after the 8th rise detect. The state change after the command byte occurs in the same cycle.
- DIO_OUT/DIO_OE change 1 cycle after fall detect, which is SYNC_STAGES+2 cycles after the pin edge.
- On STB rise detect, DIO_OE drops the next cycle, whatever the state.
- RAM_RDATA latency is 1 cycle.

## Structure
- Package tm1638_pkg holds:
  - Opcode constants for bits 7:6 (CMD_DATA=2'b01, CMD_DISP=2'b10, CMD_ADDR=2'b11).
  - Field bit positions and RAM_DEPTH=16.
  - The FSM state enum.
- It is shared with tm1638_controller.
- Sub-module tm1638_sync_edge: parameterised synchronizer plus rise/fall detect. It is instantiated for STB and CLK; DIO_IN uses the same sync without edge outputs.
- The RAM is a 16×8 register array inside the responder.

## Test plan
- Frame 0x40 followed by frame 0xC0, 0x3F, 0x06 → RAM[0]=0x3F, RAM[1]=0x06, two RAM_WE pulses with WADDR 0 then 1.
- Frame 0x44, then frame 0xC5, 0xAA, 0x55 → only RAM[5] written, final value 0x55.
- Address wrap: 0x40, then 0xCF, 0x11, 0x22 → RAM[15]=0x11, RAM[0]=0x22.
- Frame 0x8F → DISP_ON=1, BRIGHTNESS=7. Then 0x80 → DISP_ON=0, BRIGHTNESS=0.
- KEYS=0x8001_4002, frame 0x42 plus 32 clocks → master samples bytes 0x02, 0x40, 0x01, 0x80. OE low after the 32nd bit and after STB rise.
- Frame 0xC3 plus 5 bits, then STB rise → FRAME_ERR pulse, no RAM_WE, RAM[3] unchanged. RST_IN asserted mid-frame → all outputs 0 and RAM cleared.
